// File: rtl/rx_serial_7o1.sv
// rx_serial_7o1: asynchronous serial receiver (idle high, start 0, LSB-first
// data, odd parity, stop 1). Each bit is sampled at its centre, and the
// character is handed to the consumer through the tem_dado / recebe_dado
// handshake. The Moore control unit and the datapath share one registered block.
module rx_serial_7o1 #(
    parameter int M    = 5208,
    parameter int BITS = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            dado_serial,
    input  logic            recebe_dado,
    output logic [BITS-1:0] dados_ascii,
    output logic            paridade_ok,
    output logic            erro_frame,
    output logic            pronto,
    output logic            tem_dado,
    output logic [3:0]      db_estado
);

    localparam int TW = $clog2(M);
    localparam int CW = $clog2(BITS + 3);
    localparam logic [TW-1:0] HALF_LAST = TW'(M / 2 - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(M - 2);
    localparam logic [CW-1:0] NBITS     = CW'(BITS + 2);

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        DETECTA  = 4'h1,
        ESPERA   = 4'h2,
        AMOSTRA  = 4'h3,
        ARMAZENA = 4'h4,
        FINAL_RX = 4'hF
    } estado_t;

    estado_t          estado;
    logic [1:0]       sinc;
    logic [1:0]       sinc_valido;
    logic             rx;
    logic             armado;
    logic [TW-1:0]    tick;
    logic [CW-1:0]    nbit;
    logic [BITS+1:0]  desloc;

    assign rx = sinc[1];

    // Two-flop synchronizer for the asynchronous line, idling at 1 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc <= 2'b11;
        end else begin
            sinc <= {sinc[0], dado_serial};
        end
    end

    // Tracks when the synchronizer holds real line samples instead of its reset
    // value, so that a line held low through reset does not arm the receiver.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_valido <= 2'b00;
        end else begin
            sinc_valido <= {sinc_valido[0], 1'b1};
        end
    end

    // Arms start detection only after the line has genuinely been seen idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armado <= 1'b0;
        end else if (sinc_valido[1] && rx) begin
            armado <= 1'b1;
        end
    end

    // Control unit plus datapath: bit timing, shifting, result capture and handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= INICIAL;
            tick        <= '0;
            nbit        <= '0;
            desloc      <= '0;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_frame  <= 1'b0;
            pronto      <= 1'b0;
            tem_dado    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (recebe_dado) begin
                tem_dado <= 1'b0;
            end
            case (estado)
                INICIAL: begin
                    tick <= '0;
                    nbit <= '0;
                    if (armado && !rx) begin
                        estado <= DETECTA;
                    end
                end
                DETECTA: begin
                    if (tick == HALF_LAST) begin
                        tick   <= '0;
                        estado <= rx ? INICIAL : ESPERA;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ESPERA: begin
                    if (tick == WAIT_LAST) begin
                        estado <= AMOSTRA;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                AMOSTRA: begin
                    desloc <= {rx, desloc[BITS+1:1]};
                    nbit   <= nbit + CW'(1);
                    tick   <= '0;
                    if (nbit + CW'(1) == NBITS) begin
                        estado <= ARMAZENA;
                    end else begin
                        estado <= ESPERA;
                    end
                end
                ARMAZENA: begin
                    dados_ascii <= desloc[BITS-1:0];
                    paridade_ok <= ^desloc[BITS:0];
                    erro_frame  <= ~desloc[BITS+1];
                    tem_dado    <= 1'b1;
                    pronto      <= 1'b1;
                    estado      <= FINAL_RX;
                end
                FINAL_RX: begin
                    estado <= INICIAL;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Debug view of the state; any corrupted code reads back as E.
    always_comb begin
        db_estado = 4'hE;
        case (estado)
            INICIAL:  db_estado = 4'h0;
            DETECTA:  db_estado = 4'h1;
            ESPERA:   db_estado = 4'h2;
            AMOSTRA:  db_estado = 4'h3;
            ARMAZENA: db_estado = 4'h4;
            FINAL_RX: db_estado = 4'hF;
            default:  db_estado = 4'hE;
        endcase
    end

endmodule
